// File: rtl/round_sequencer.sv
// round_sequencer: one fight match - 3-2-1 countdown, timed rounds, KO/timeout scoring,
// inter-round hold and best-of-N result. Define PAUSE_EN to build in pause support.
module round_sequencer #(
  parameter int TICKS_PER_SEC  = 60,
  parameter int COUNT_FROM     = 3,
  parameter int ROUND_SECS     = 99,
  parameter int ROUNDS_TO_WIN  = 2,
  parameter int MAX_ROUNDS     = 3,
  parameter int END_HOLD_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_ko,
  input  logic       p2_ko,
  input  logic       pause_btn,
  output logic       countdown_active,
  output logic [3:0] countdown_val,
  output logic       countdown_done,
  output logic       play_active,
  output logic [6:0] timer_sec,
  output logic [1:0] round_num,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic       round_over,
  output logic       match_over,
  output logic [1:0] winner,
  output logic       paused
);

  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int HOLD_W = (END_HOLD_TICKS > 1) ? $clog2(END_HOLD_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(END_HOLD_TICKS - 1);
  localparam logic [3:0]        CD_START   = 4'(COUNT_FROM);
  localparam logic [6:0]        SECS_START = 7'(ROUND_SECS);
  localparam logic [1:0]        WIN_ROUNDS = 2'(ROUNDS_TO_WIN);
  localparam logic [1:0]        LAST_ROUND = 2'(MAX_ROUNDS);

  typedef enum logic [2:0] {IDLE, COUNTDOWN, FIGHT, ROUND_END, MATCH_END} state_t;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  function automatic logic [6:0] sat_dec7(input logic [6:0] v);
    return (v == 7'd0) ? v : v - 7'd1;
  endfunction

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        cval_q, cval_d;
  logic [6:0]        timer_q, timer_d;
  logic [1:0]        round_q, round_d;
  logic [1:0]        p1_q, p1_d;
  logic [1:0]        p2_q, p2_d;
  logic              start_low_q, start_low_d;
  logic              start_rise, in_play, frozen, run, sec_tick;

  // start_low_q resets to 0, so a start held high through reset needs a low sample first
  assign start_rise = start & start_low_q;
  assign in_play    = (state_q == COUNTDOWN) || (state_q == FIGHT);
  assign run        = in_play & ~frozen;
  assign sec_tick   = run && (tick_q == TICK_LAST);

`ifdef PAUSE_EN
  logic paused_q, paused_d, pause_low_q, pause_low_d, pause_rise;

  assign pause_rise = pause_btn & pause_low_q;
  assign frozen     = paused_q;

  always_comb begin
    pause_low_d = ~pause_btn;
    paused_d    = paused_q;
    if (pause_rise && in_play) paused_d = ~paused_q;
    if ((state_d != COUNTDOWN) && (state_d != FIGHT)) paused_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      paused_q    <= 1'b0;
      pause_low_q <= 1'b0;
    end else begin
      paused_q    <= paused_d;
      pause_low_q <= pause_low_d;
    end
  end
`else
  logic unused_pause;
  assign unused_pause = pause_btn;
  assign frozen       = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    tick_d         = tick_q;
    hold_d         = hold_q;
    cval_d         = cval_q;
    timer_d        = timer_q;
    round_d        = round_q;
    p1_d           = p1_q;
    p2_d           = p2_q;
    start_low_d    = ~start;
    countdown_done = 1'b0;
    if (run) tick_d = sec_tick ? '0 : tick_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d = COUNTDOWN;
          round_d = 2'd1;
          p1_d    = '0;
          p2_d    = '0;
          cval_d  = CD_START;
          tick_d  = '0;
        end
      end
      COUNTDOWN: begin
        if (sec_tick) begin
          if (cval_q == 4'd1) begin
            state_d        = FIGHT;
            countdown_done = 1'b1;
            timer_d        = SECS_START;
            cval_d         = '0;
          end else begin
            cval_d = cval_q - 4'd1;
          end
        end
      end
      FIGHT: begin
        if (sec_tick) timer_d = sat_dec7(timer_q);
        // a KO landing on the timeout frame decides the round instead of the draw
        if (!frozen && (p1_ko || p2_ko)) begin
          state_d = ROUND_END;
          hold_d  = '0;
          if (p2_ko && !p1_ko) p1_d = sat_inc2(p1_q);
          if (p1_ko && !p2_ko) p2_d = sat_inc2(p2_q);
        end else if (sec_tick && (timer_q <= 7'd1)) begin
          state_d = ROUND_END;
          hold_d  = '0;
        end
      end
      ROUND_END: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if ((p1_q == WIN_ROUNDS) || (p2_q == WIN_ROUNDS) || (round_q == LAST_ROUND)) begin
            state_d = MATCH_END;
          end else begin
            state_d = COUNTDOWN;
            round_d = sat_inc2(round_q);
            cval_d  = CD_START;
            tick_d  = '0;
          end
        end
      end
      MATCH_END: begin
        if (start_rise) begin
          state_d = IDLE;
          round_d = '0;
          p1_d    = '0;
          p2_d    = '0;
          timer_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      hold_q      <= '0;
      cval_q      <= '0;
      timer_q     <= '0;
      round_q     <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      start_low_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      hold_q      <= hold_d;
      cval_q      <= cval_d;
      timer_q     <= timer_d;
      round_q     <= round_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      start_low_q <= start_low_d;
    end
  end

  assign countdown_active = (state_q == COUNTDOWN);
  assign countdown_val    = cval_q;
  assign play_active      = (state_q == FIGHT) && !frozen;
  assign timer_sec        = timer_q;
  assign round_num        = round_q;
  assign p1_rounds        = p1_q;
  assign p2_rounds        = p2_q;
  assign round_over       = (state_q == ROUND_END) && (hold_q == '0);
  assign match_over       = (state_q == MATCH_END);
  assign winner           = !match_over   ? 2'd0 :
                            (p1_q > p2_q) ? 2'd1 :
                            (p2_q > p1_q) ? 2'd2 : 2'd0;
  assign paused           = frozen;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with an elapsed-frame reference model checked every cycle.
// Builds with or without PAUSE_EN; the pause scenario follows the macro.
module tb_round_sequencer;

  localparam int TPS  = 4;
  localparam int CF   = 3;
  localparam int RS   = 5;
  localparam int RTW  = 2;
  localparam int MAXR = 3;
  localparam int HOLD = 8;
`ifdef PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, p1_ko, p2_ko, pause_btn;
  logic countdown_active, countdown_done, play_active, round_over, match_over, paused;
  logic [3:0] countdown_val;
  logic [6:0] timer_sec;
  logic [1:0] round_num, p1_rounds, p2_rounds, winner;

  int checks = 0;
  int errors = 0;

  round_sequencer #(
    .TICKS_PER_SEC(TPS), .COUNT_FROM(CF), .ROUND_SECS(RS),
    .ROUNDS_TO_WIN(RTW), .MAX_ROUNDS(MAXR), .END_HOLD_TICKS(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .p1_ko(p1_ko), .p2_ko(p2_ko),
    .pause_btn(pause_btn), .countdown_active(countdown_active),
    .countdown_val(countdown_val), .countdown_done(countdown_done),
    .play_active(play_active), .timer_sec(timer_sec), .round_num(round_num),
    .p1_rounds(p1_rounds), .p2_rounds(p2_rounds), .round_over(round_over),
    .match_over(match_over), .winner(winner), .paused(paused)
  );

  always #5 clk = ~clk;

  // phase: 0 idle, 1 countdown, 2 fight, 3 round end, 4 match end; el = frames spent in phase
  typedef struct packed {
    int   phase;
    int   el;
    int   rnd;
    int   s1;
    int   s2;
    int   thold;
    logic start_low;
    logic pause_low;
    logic psd;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t c, logic st, logic k1, logic k2, logic pb);
    model_t n;
    logic srise, prise, was_paused;
    n          = c;
    srise      = st && c.start_low;
    prise      = pb && c.pause_low;
    was_paused = PAUSE_ON && c.psd;
    n.start_low = !st;
    n.pause_low = !pb;
    case (c.phase)
      0: if (srise) begin
        n.phase = 1; n.el = 0; n.rnd = 1; n.s1 = 0; n.s2 = 0;
      end
      1: if (!was_paused) begin
        if (c.el == CF * TPS - 1) begin n.phase = 2; n.el = 0; end
        else n.el = c.el + 1;
      end
      2: if (!was_paused) begin
        if (k1 || k2) begin
          n.thold = RS - (c.el + 1) / TPS;
          if (k2 && !k1) n.s1 = c.s1 + 1;
          if (k1 && !k2) n.s2 = c.s2 + 1;
          n.phase = 3; n.el = 0;
        end else if (c.el == RS * TPS - 1) begin
          n.thold = 0; n.phase = 3; n.el = 0;
        end else n.el = c.el + 1;
      end
      3: if (c.el == HOLD - 1) begin
        n.el = 0;
        if (c.s1 == RTW || c.s2 == RTW || c.rnd == MAXR) n.phase = 4;
        else begin n.rnd = c.rnd + 1; n.phase = 1; end
      end else n.el = c.el + 1;
      4: if (srise) begin
        n.phase = 0; n.rnd = 0; n.s1 = 0; n.s2 = 0; n.thold = 0;
      end
      default: n.phase = 0;
    endcase
    if (PAUSE_ON && prise && (c.phase == 1 || c.phase == 2)) n.psd = !c.psd;
    if (n.phase != 1 && n.phase != 2) n.psd = 1'b0;
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= '0;
    else        m <= model_next(m, start, p1_ko, p2_ko, pause_btn);
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("m_cd_active", countdown_active, m.phase == 1);
      check("m_cd_val", countdown_val, (m.phase == 1) ? CF - m.el / TPS : 0);
      check("m_cd_done", countdown_done, m.phase == 1 && m.el == CF * TPS - 1 && !m.psd);
      check("m_play", play_active, m.phase == 2 && !m.psd);
      check("m_timer", timer_sec, (m.phase == 2) ? RS - m.el / TPS : m.thold);
      check("m_round", round_num, m.rnd);
      check("m_p1", p1_rounds, m.s1);
      check("m_p2", p2_rounds, m.s2);
      check("m_round_over", round_over, m.phase == 3 && m.el == 0);
      check("m_match_over", match_over, m.phase == 4);
      check("m_winner", winner, (m.phase != 4) ? 0 : (m.s1 > m.s2) ? 1 : (m.s2 > m.s1) ? 2 : 0);
      check("m_paused", paused, m.psd);
    end
  end

  function automatic bit cond(input int sel);
    case (sel)
      0:       return play_active == 1'b1;
      1:       return match_over == 1'b1;
      default: return timer_sec == 7'd3;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for(input int sel, input int budget, input string name);
    int n;
    n = 0;
    while (!cond(sel) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cond(sel)) begin
      errors++;
      $display("FAIL %s: waited %0d cycles, condition required within %0d", name, n, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; p1_ko = 1'b0; p2_ko = 1'b0; pause_btn = 1'b0;
    tick(3);
    check("rst_round", round_num, 0);
    check("rst_timer", timer_sec, 0);
    check("rst_cd", countdown_active, 0);
    reset = 1'b1;
    tick(2);

    // countdown 3,2,1 then first fight frame
    start = 1'b1; tick(1);
    check("t1_cv3", countdown_val, 3);
    check("t1_round", round_num, 1);
    tick(4); check("t1_cv2", countdown_val, 2);
    tick(4); check("t1_cv1", countdown_val, 1);
    tick(3); check("t1_done", countdown_done, 1);
    tick(1);
    check("t1_play", play_active, 1);
    check("t1_timer", timer_sec, 5);
    check("t1_done_off", countdown_done, 0);
    start = 1'b0;

    // P1 wins round 1 by KO, hold, round 2 countdown
    tick(5); check("t2_timer4", timer_sec, 4);
    p2_ko = 1'b1; tick(1); p2_ko = 1'b0;
    check("t2_round_over", round_over, 1);
    check("t2_p1", p1_rounds, 1);
    check("t2_play_off", play_active, 0);
    tick(1); check("t2_ro_pulse", round_over, 0);
    tick(7);
    check("t2_cd", countdown_active, 1);
    check("t2_round2", round_num, 2);

    // P1 wins round 2 -> match end
    tick(12); check("t3_play", play_active, 1);
    p2_ko = 1'b1; tick(1); p2_ko = 1'b0;
    check("t3_p1", p1_rounds, 2);
    tick(8);
    check("t3_match", match_over, 1);
    check("t3_winner", winner, 1);
    p1_ko = 1'b1; tick(1); p1_ko = 1'b0;
    start = 1'b1; tick(1);
    check("t3_idle_round", round_num, 0);
    check("t3_idle_p1", p1_rounds, 0);
    check("t3_idle_match", match_over, 0);
    start = 1'b0; tick(1);

    // timeout draws x3
    start = 1'b1; tick(1); start = 1'b0;
    tick(12); check("t4_timer5", timer_sec, 5);
    tick(19); check("t4_timer1", timer_sec, 1);
    tick(1);
    check("t4_round_over", round_over, 1);
    check("t4_timer0", timer_sec, 0);
    p1_ko = 1'b1; tick(1); p1_ko = 1'b0;
    wait_for(1, 200, "t4_wait_match");
    check("t4_winner", winner, 0);
    check("t4_round3", round_num, 3);
    check("t4_p2", p2_rounds, 0);

    // double KO draw, then async reset mid-fight
    start = 1'b1; tick(1); start = 1'b0; tick(1);
    start = 1'b1; tick(1); start = 1'b0;
    wait_for(0, 40, "t5_wait_play");
    tick(2);
    p1_ko = 1'b1; p2_ko = 1'b1; tick(1); p1_ko = 1'b0; p2_ko = 1'b0;
    check("t5_dko_over", round_over, 1);
    check("t5_dko_p1", p1_rounds, 0);
    check("t5_dko_p2", p2_rounds, 0);
    wait_for(0, 40, "t5_wait_play2");
    tick(3);
    #2 reset = 1'b0;
    #1;
    check("t5_async_play", play_active, 0);
    check("t5_async_timer", timer_sec, 0);
    check("t5_async_round", round_num, 0);
    start = 1'b1;
    @(negedge clk); reset = 1'b1;
    tick(3); check("t5_start_held", countdown_active, 0);
    start = 1'b0; tick(1);
    start = 1'b1; tick(1); check("t5_start_edge", countdown_active, 1);
    start = 1'b0;

    // P2 takes the match
    wait_for(0, 40, "t5_wait_r1");
    p1_ko = 1'b1; tick(1); p1_ko = 1'b0;
    wait_for(0, 40, "t5_wait_r2");
    p1_ko = 1'b1; tick(1); p1_ko = 1'b0;
    wait_for(1, 40, "t5_wait_match");
    check("t5_winner", winner, 2);
    check("t5_p2", p2_rounds, 2);
    check("t5_round", round_num, 2);

    // pause behaviour
    start = 1'b1; tick(1); start = 1'b0; tick(1);
    start = 1'b1; tick(1); start = 1'b0;
    wait_for(0, 40, "t6_wait_play");
    wait_for(2, 40, "t6_wait_t3");
    pause_btn = 1'b1; tick(1); pause_btn = 1'b0;
`ifdef PAUSE_EN
    check("t6_paused", paused, 1);
    check("t6_play_off", play_active, 0);
    p2_ko = 1'b1; tick(1); p2_ko = 1'b0;
    tick(49);
    check("t6_frozen_timer", timer_sec, 3);
    check("t6_frozen_p1", p1_rounds, 0);
    pause_btn = 1'b1; tick(1); pause_btn = 1'b0;
    check("t6_resumed", paused, 0);
    check("t6_play_on", play_active, 1);
    check("t6_timer_resume", timer_sec, 3);
`else
    check("t6_no_pause", paused, 0);
    check("t6_still_play", play_active, 1);
`endif
    tick(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
